mvd_bin_parser: RTL and testbench

//  Decoder-side inverse of the MVD bit estimator: consumes mvd_coding bins, one per handshake, in HEVC order.

---
 rtl/mvd_bin_parser_if.sv | 29 ++
 rtl/mvd_bin_parser.sv | 187 ++++++++++++++++++
 tb/tb_mvd_bin_parser.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvd_bin_parser_if.sv
// Bin stream and result bundle between the bin decoder, the MVD bin parser and its consumers.
// The master drives start/mvp/bins; the slave (parser) returns ready and the reconstructed MV.
interface mvd_bin_parser_if #(
    parameter int FMV_WIDTH = 10,
    parameter int MVD_WIDTH = 11
);
    // A bin moves when bin_valid_i & bin_ready_o are high on a rising clock edge;
    // ready never depends on valid, and valid may drop between bins at any time.
    logic                       start_i;
    logic [2*FMV_WIDTH-1:0]     mvp_i;
    logic                       bin_i;
    logic                       bin_valid_i;
    logic                       bin_ready_o;
    logic [2*FMV_WIDTH-1:0]     mv_o;
    logic [2*MVD_WIDTH-1:0]     mvd_o;
    logic [5:0]                 mv_bits_cnt_o;
    logic                       done_o;
    logic                       err_o;

    modport master (
        output start_i, mvp_i, bin_i, bin_valid_i,
        input  bin_ready_o, mv_o, mvd_o, mv_bits_cnt_o, done_o, err_o
    );

    modport slave (
        input  start_i, mvp_i, bin_i, bin_valid_i,
        output bin_ready_o, mv_o, mvd_o, mv_bits_cnt_o, done_o, err_o
    );
endinterface

// File: rtl/mvd_bin_parser.sv
// Rebuilds mvd/mv from HEVC mvd_coding bins (greater0, greater1, EG1 abs_minus2, sign).
// Optional MVD_BITS_CNT_EN builds the saturating consumed-bin counter; otherwise mv_bits_cnt_o is 0.
module mvd_bin_parser #(
    parameter int FMV_WIDTH = 10,
    parameter int MVD_WIDTH = 11
) (
    input  logic                clk,
    input  logic                rstn,
    mvd_bin_parser_if.slave     bus,
    output logic [3:0]          o_dbg_state
);
    localparam int KW = $clog2(MVD_WIDTH) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_G0X, S_G0Y, S_G1X, S_G1Y,
        S_PFX_X, S_SFX_X, S_SGN_X, S_PFX_Y, S_SFX_Y, S_SGN_Y, S_DONE
    } state_t;

    state_t                 r_state, w_state_nxt, w_x_entry, w_y_entry;
    logic [2*FMV_WIDTH-1:0] r_mvp;
    logic                   r_g0x, r_g0y, r_g1x, r_g1y, r_negx, r_negy;
    logic                   w_g0x_nxt, w_g0y_nxt, w_g1x_nxt, w_g1y_nxt, w_negx_nxt, w_negy_nxt;
    logic [KW-1:0]          r_k, w_k_nxt;
    logic [MVD_WIDTH-1:0]   r_valx, r_valy, w_valx_nxt, w_valy_nxt;
    logic [MVD_WIDTH-1:0]   w_pfx_inc, w_sfx_inc, w_absx, w_absy, w_mvdx, w_mvdy;
    logic [FMV_WIDTH-1:0]   w_mvx, w_mvy;
    logic                   w_acc, w_ovf, w_load;
    logic [2*FMV_WIDTH-1:0] r_mv_o;
    logic [2*MVD_WIDTH-1:0] r_mvd_o;
    logic                   r_done_o, r_err_o;

    assign bus.bin_ready_o = (r_state != S_IDLE) && (r_state != S_DONE);
    // A bin that coincides with start_i belongs to the aborted parse and is dropped.
    assign w_acc     = bus.bin_valid_i & bus.bin_ready_o & ~bus.start_i;
    assign w_pfx_inc = MVD_WIDTH'(1) << r_k;
    assign w_sfx_inc = MVD_WIDTH'(bus.bin_i) << (r_k - KW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_g0x_nxt   = r_g0x;
        w_g0y_nxt   = r_g0y;
        w_g1x_nxt   = r_g1x;
        w_g1y_nxt   = r_g1y;
        w_negx_nxt  = r_negx;
        w_negy_nxt  = r_negy;
        w_k_nxt     = r_k;
        w_valx_nxt  = r_valx;
        w_valy_nxt  = r_valy;
        w_ovf       = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_G0X: w_g0x_nxt = bus.bin_i;
                S_G0Y: w_g0y_nxt = bus.bin_i;
                S_G1X: w_g1x_nxt = bus.bin_i;
                S_G1Y: w_g1y_nxt = bus.bin_i;
                S_PFX_X, S_PFX_Y: begin
                    if (bus.bin_i) begin
                        if (r_k == KW'(MVD_WIDTH - 1)) begin
                            w_ovf = 1'b1;
                        end else begin
                            w_k_nxt = r_k + KW'(1);
                            if (r_state == S_PFX_X) w_valx_nxt = r_valx + w_pfx_inc;
                            else                    w_valy_nxt = r_valy + w_pfx_inc;
                        end
                    end
                end
                S_SFX_X, S_SFX_Y: begin
                    // k returns to 1 after the last suffix bin, ready for the other component.
                    w_k_nxt = (r_k == KW'(1)) ? KW'(1) : r_k - KW'(1);
                    if (r_state == S_SFX_X) w_valx_nxt = r_valx + w_sfx_inc;
                    else                    w_valy_nxt = r_valy + w_sfx_inc;
                end
                S_SGN_X: w_negx_nxt = bus.bin_i;
                S_SGN_Y: w_negy_nxt = bus.bin_i;
                default: ;
            endcase
        end

        w_y_entry = w_g0y_nxt ? (w_g1y_nxt ? S_PFX_Y : S_SGN_Y) : S_DONE;
        w_x_entry = w_g0x_nxt ? (w_g1x_nxt ? S_PFX_X : S_SGN_X) : w_y_entry;

        case (r_state)
            S_G0X:   if (w_acc) w_state_nxt = S_G0Y;
            S_G0Y:   if (w_acc) w_state_nxt = w_g0x_nxt ? S_G1X : (w_g0y_nxt ? S_G1Y : w_x_entry);
            S_G1X:   if (w_acc) w_state_nxt = r_g0y ? S_G1Y : w_x_entry;
            S_G1Y:   if (w_acc) w_state_nxt = w_x_entry;
            S_PFX_X: if (w_acc) w_state_nxt = w_ovf ? S_IDLE : (bus.bin_i ? S_PFX_X : S_SFX_X);
            S_SFX_X: if (w_acc && r_k == KW'(1)) w_state_nxt = S_SGN_X;
            S_SGN_X: if (w_acc) w_state_nxt = w_y_entry;
            S_PFX_Y: if (w_acc) w_state_nxt = w_ovf ? S_IDLE : (bus.bin_i ? S_PFX_Y : S_SFX_Y);
            S_SFX_Y: if (w_acc && r_k == KW'(1)) w_state_nxt = S_SGN_Y;
            S_SGN_Y: if (w_acc) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (bus.start_i) begin
            w_state_nxt = S_G0X;
            w_g0x_nxt   = 1'b0;
            w_g0y_nxt   = 1'b0;
            w_g1x_nxt   = 1'b0;
            w_g1y_nxt   = 1'b0;
            w_negx_nxt  = 1'b0;
            w_negy_nxt  = 1'b0;
            w_k_nxt     = KW'(1);
            w_valx_nxt  = '0;
            w_valy_nxt  = '0;
        end
    end

    // Results are formed from the post-accept values so they register on the last bin's edge.
    assign w_absx = w_g0x_nxt ? (w_g1x_nxt ? w_valx_nxt + MVD_WIDTH'(2) : MVD_WIDTH'(1)) : '0;
    assign w_absy = w_g0y_nxt ? (w_g1y_nxt ? w_valy_nxt + MVD_WIDTH'(2) : MVD_WIDTH'(1)) : '0;
    assign w_mvdx = w_negx_nxt ? ('0 - w_absx) : w_absx;
    assign w_mvdy = w_negy_nxt ? ('0 - w_absy) : w_absy;
    assign w_mvx  = r_mvp[FMV_WIDTH-1:0] + w_mvdx[FMV_WIDTH-1:0];
    assign w_mvy  = r_mvp[2*FMV_WIDTH-1:FMV_WIDTH] + w_mvdy[FMV_WIDTH-1:0];
    assign w_load = (w_state_nxt == S_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_mvp    <= '0;
            r_g0x    <= 1'b0;
            r_g0y    <= 1'b0;
            r_g1x    <= 1'b0;
            r_g1y    <= 1'b0;
            r_negx   <= 1'b0;
            r_negy   <= 1'b0;
            r_k      <= '0;
            r_valx   <= '0;
            r_valy   <= '0;
            r_mv_o   <= '0;
            r_mvd_o  <= '0;
            r_done_o <= 1'b0;
            r_err_o  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_g0x    <= w_g0x_nxt;
            r_g0y    <= w_g0y_nxt;
            r_g1x    <= w_g1x_nxt;
            r_g1y    <= w_g1y_nxt;
            r_negx   <= w_negx_nxt;
            r_negy   <= w_negy_nxt;
            r_k      <= w_k_nxt;
            r_valx   <= w_valx_nxt;
            r_valy   <= w_valy_nxt;
            r_done_o <= w_load;
            r_err_o  <= w_ovf;
            if (bus.start_i) r_mvp <= bus.mvp_i;
            if (w_load) begin
                r_mv_o  <= {w_mvy, w_mvx};
                r_mvd_o <= {w_mvdy, w_mvdx};
            end
        end
    end

`ifdef MVD_BITS_CNT_EN
    logic [5:0] r_cnt, w_cnt_nxt, r_cnt_o;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.start_i)                w_cnt_nxt = '0;
        else if (w_acc && r_cnt != 6'd63) w_cnt_nxt = r_cnt + 6'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_cnt_o <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_load) r_cnt_o <= w_cnt_nxt;
        end
    end

    assign bus.mv_bits_cnt_o = r_cnt_o;
`else
    assign bus.mv_bits_cnt_o = 6'd0;
`endif

    assign bus.mv_o    = r_mv_o;
    assign bus.mvd_o   = r_mvd_o;
    assign bus.done_o  = r_done_o;
    assign bus.err_o   = r_err_o;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mvd_bin_parser.sv
// Randomised bench for mvd_bin_parser against a bin-list decoding model of mvd_coding.
// Counter expectations follow MVD_BITS_CNT_EN the same way the design build does.
module tb_mvd_bin_parser;
    localparam int FMV_WIDTH = 10;
    localparam int MVD_WIDTH = 11;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] dbg_state;

    mvd_bin_parser_if #(.FMV_WIDTH(FMV_WIDTH), .MVD_WIDTH(MVD_WIDTH)) bus ();

    mvd_bin_parser #(.FMV_WIDTH(FMV_WIDTH), .MVD_WIDTH(MVD_WIDTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          t0 = 0;
    int          last_lat = 0;
    int          rd_idx = 0;
    bit          bins_q[$];
    int          gap_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] held = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.done_o) n_done = n_done + 1;
        if (bus.err_o)  n_err = n_err + 1;
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit nb();
        bit b;
        b = bins_q[rd_idx];
        rd_idx++;
        return b;
    endfunction

    // Decodes the bin list straight from the mvd_coding syntax; result packed {cnt, mv_y, mv_x, mvd_y, mvd_x}.
    function automatic void ref_model(input int mvpx, input int mvpy, output logic [47:0] e, output bit err);
        bit          g0[2];
        bit          g1[2];
        bit          neg[2];
        int          absv[2];
        int          mvp[2];
        logic [10:0] mvd[2];
        logic [9:0]  mv[2];
        int          k, val, suf, cnt;
        mvp[0] = mvpx;
        mvp[1] = mvpy;
        rd_idx = 0;
        err = 1'b0;
        e = '0;
        g0[0] = nb();
        g0[1] = nb();
        for (int c = 0; c < 2; c++) g1[c] = g0[c] ? nb() : 1'b0;
        for (int c = 0; c < 2; c++) begin
            absv[c] = 0;
            neg[c] = 1'b0;
            if (g0[c] && g1[c]) begin
                k = 1;
                val = 0;
                while (nb()) begin
                    if (k == MVD_WIDTH - 1) begin
                        err = 1'b1;
                        return;
                    end
                    val += (1 << k);
                    k++;
                end
                suf = 0;
                for (int j = 0; j < k; j++) suf = suf * 2 + int'(nb());
                absv[c] = 2 + val + suf;
            end else if (g0[c]) begin
                absv[c] = 1;
            end
            if (g0[c]) neg[c] = nb();
            mvd[c] = 11'(neg[c] ? -absv[c] : absv[c]);
            mv[c] = 10'(mvp[c] + int'($signed(mvd[c])));
        end
`ifdef MVD_BITS_CNT_EN
        cnt = (rd_idx > 63) ? 63 : rd_idx;
`else
        cnt = 0;
`endif
        e = {6'(cnt), mv[1], mv[0], mvd[1], mvd[0]};
    endfunction

    task automatic gen_comp(input bit g0, input bit g1, input bit ovf, output bit stop);
        int n;
        stop = 1'b0;
        if (g0 && g1) begin
            if (ovf) begin
                repeat (10) bins_q.push_back(1'b1);
                stop = 1'b1;
                return;
            end
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2);
            repeat (n) bins_q.push_back(1'b1);
            bins_q.push_back(1'b0);
            repeat (n + 1) bins_q.push_back(1'($urandom_range(0, 1)));
        end
        if (g0) bins_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic gen_random();
        bit g0x, g0y, g1x, g1y, stop, ovf;
        bins_q.delete();
        g0x = ($urandom_range(0, 3) != 0);
        g0y = ($urandom_range(0, 3) != 0);
        g1x = 1'($urandom_range(0, 1));
        g1y = 1'($urandom_range(0, 1));
        ovf = ($urandom_range(0, 7) == 0);
        bins_q.push_back(g0x);
        bins_q.push_back(g0y);
        if (g0x) bins_q.push_back(g1x);
        if (g0y) bins_q.push_back(g1y);
        gen_comp(g0x, g1x, ovf, stop);
        if (!stop) gen_comp(g0y, g1y, ovf, stop);
    endtask

    task automatic fill_gaps(input int maxg);
        gap_q.delete();
        for (int i = 0; i < bins_q.size(); i++) gap_q.push_back($urandom_range(0, maxg));
    endtask

    task automatic do_start(input int mvpx, input int mvpy, input bit junk);
        bus.start_i = 1'b1;
        bus.mvp_i = {10'(mvpy), 10'(mvpx)};
        bus.bin_valid_i = junk;
        bus.bin_i = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        bus.start_i = 1'b0;
        bus.bin_valid_i = 1'b0;
    endtask

    task automatic feed(input int n, output int gaps);
        int w;
        gaps = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                bus.bin_valid_i = 1'b0;
                @(posedge clk); #1;
                gaps++;
            end
            bus.bin_valid_i = 1'b1;
            bus.bin_i = bins_q[i];
            w = 0;
            while (!bus.bin_ready_o && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 50) begin
                chk("ready_timeout", 48'(bus.bin_ready_o), 48'd1);
                bus.bin_valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.bin_valid_i = 1'b0;
    endtask

    task automatic run_parse(input int mvpx, input int mvpy, input bit junk);
        logic [47:0] e;
        bit          err;
        int          gaps, nd0, ne0;
        ref_model(mvpx, mvpy, e, err);
        nd0 = n_done;
        ne0 = n_err;
        do_start(mvpx, mvpy, junk);
        feed(bins_q.size(), gaps);
        last_lat = cyc - t0;
        chk("latency", 48'(last_lat), 48'(bins_q.size() + gaps));
        if (err) begin
            chk("err_pulse", 48'(bus.err_o), 48'd1);
            chk("err_no_done", 48'(bus.done_o), 48'd0);
            chk("err_idle", 48'(dbg_state), 48'd0);
            chk("err_hold", 48'({bus.mv_bits_cnt_o, bus.mv_o, bus.mvd_o}), held);
            @(posedge clk); #1;
            chk("err_1cyc", 48'(bus.err_o), 48'd0);
            chk("err_done_cnt", 48'(n_done - nd0), 48'd0);
        end else begin
            exp_q.push_back(e);
            chk("done_pulse", 48'(bus.done_o), 48'd1);
            chk("no_err", 48'(bus.err_o), 48'd0);
            e = exp_q.pop_front();
            held = e;
            chk("mvd", 48'(bus.mvd_o), 48'(e[21:0]));
            chk("mv", 48'(bus.mv_o), 48'(e[41:22]));
            chk("cnt", 48'(bus.mv_bits_cnt_o), 48'(e[47:42]));
            @(posedge clk); #1;
            chk("done_1cyc", 48'(bus.done_o), 48'd0);
            chk("done_cnt", 48'(n_done - nd0), 48'd1);
            chk("no_err_cnt", 48'(n_err - ne0), 48'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mv"}, 48'(bus.mv_o), 48'd0);
        chk({tag, "_mvd"}, 48'(bus.mvd_o), 48'd0);
        chk({tag, "_cnt"}, 48'(bus.mv_bits_cnt_o), 48'd0);
        chk({tag, "_done"}, 48'(bus.done_o), 48'd0);
        chk({tag, "_err"}, 48'(bus.err_o), 48'd0);
        chk({tag, "_ready"}, 48'(bus.bin_ready_o), 48'd0);
        chk({tag, "_state"}, 48'(dbg_state), 48'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got %0d exp %0d", cyc, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int g, nd0;
        logic [5:0] c_exp;
`ifdef MVD_BITS_CNT_EN
        c_exp = 6'd1;
`else
        c_exp = 6'd0;
`endif
        bus.start_i = 1'b0;
        bus.mvp_i = '0;
        bus.bin_i = 1'b0;
        bus.bin_valid_i = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Bins offered while idle must not be taken.
        bus.bin_valid_i = 1'b1;
        bus.bin_i = 1'b1;
        repeat (3) begin
            chk("idle_ready", 48'(bus.bin_ready_o), 48'd0);
            @(posedge clk); #1;
        end
        bus.bin_valid_i = 1'b0;

        bins_q = '{1'b0, 1'b0};
        fill_gaps(0);
        run_parse(0, 0, 1'b0);
        chk("c1_lat", 48'(last_lat), 48'd2);
        chk("c1_cnt", 48'(bus.mv_bits_cnt_o), 48'(c_exp * 6'd2));

        bins_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        fill_gaps(0);
        run_parse(5, -3, 1'b0);
        chk("c2_mvd", 48'(bus.mvd_o), 48'({11'h7FF, 11'd1}));
        chk("c2_mv", 48'(bus.mv_o), 48'({10'h3FC, 10'd6}));

        bins_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        fill_gaps(0);
        run_parse(0, 10, 1'b0);
        chk("c3_mvd", 48'(bus.mvd_o), 48'({11'd0, 11'd7}));
        chk("c3_mv", 48'(bus.mv_o), 48'({10'd10, 10'd7}));
        chk("c3_lat", 48'(last_lat), 48'd8);

        gap_q = '{0, 0, 3, 0, 0, 3, 0, 0};
        run_parse(0, 10, 1'b0);
        chk("c4_mv", 48'(bus.mv_o), 48'({10'd10, 10'd7}));
        chk("c4_lat", 48'(last_lat), 48'd14);

        // Abort after three bins, restart with a coincident bin that must be dropped.
        nd0 = n_done;
        bins_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        fill_gaps(0);
        do_start(5, -3, 1'b0);
        feed(3, g);
        bins_q = '{1'b0, 1'b0};
        fill_gaps(0);
        run_parse(0, 0, 1'b1);
        chk("c5_done_total", 48'(n_done - nd0), 48'd1);
        chk("c5_mv", 48'(bus.mv_o), 48'd0);
        chk("c5_cnt", 48'(bus.mv_bits_cnt_o), 48'(c_exp * 6'd2));

        bins_q = '{1'b1, 1'b0, 1'b1};
        repeat (10) bins_q.push_back(1'b1);
        fill_gaps(1);
        run_parse(3, 4, 1'b0);
        chk("c6_mv_hold", 48'(bus.mv_o), 48'd0);

        bins_q = '{1'b1, 1'b0, 1'b0, 1'b0};
        fill_gaps(0);
        run_parse(511, 0, 1'b0);
        chk("wrap_mv", 48'(bus.mv_o), 48'({10'd0, 10'h200}));

        // Reset in the middle of a parse drops everything.
        gen_random();
        fill_gaps(0);
        nd0 = n_done;
        do_start(17, 23, 1'b0);
        feed(2, g);
        #2 rstn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rstn = 1'b1;
        held = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", 48'(n_done - nd0), 48'd0);

        for (int i = 0; i < 60; i++) begin
            gen_random();
            fill_gaps((i % 2 == 0) ? 0 : 2);
            run_parse(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
